// File: rtl/snell_seq_divider_if.sv
// Start/done handshake bundle between the n2*sin(theta2) multiplier
// and the n1 divider stage.
interface snell_seq_divider_if #(
    parameter int DW = 13,
    parameter int SW = 9,
    parameter int QW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] n1;
    logic          sat;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, n1, sat, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, n1, sat, div_zero
    );
endinterface

// File: rtl/snell_seq_divider.sv
// Restoring divider producing n1 (q2.2) from a q3.10 product and a
// q1.8 sine, with round-half-up, saturation and divide-by-zero flag.
module snell_seq_divider #(
    parameter int DW    = 13,
    parameter int SW    = 9,
    parameter int QW    = 4,
    parameter int ROUND = 1
) (
    input  logic clk,
    input  logic rst,
    snell_seq_divider_if.slave bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, RND, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] rem_q;
    logic [DW-1:0] quo_q;
    logic [SW-1:0] dsr_q;
    logic          dz_q;
    logic [QW-1:0] res_q;
    logic          rsat_q;
    logic          busy_q;
    logic          done_q;
    logic [QW-1:0] n1_q;
    logic          sat_q;
    logic          dzo_q;

    logic [SW:0]   rem_sh_d;
    logic          ge_d;
    logic [SW-1:0] rem_d;
    logic [DW-1:0] quo_d;
    logic          rup_d;
    logic [DW:0]   qr_d;
    logic          ovf_d;

    always_comb begin
        rem_sh_d = {rem_q, quo_q[DW-1]};
        ge_d     = rem_sh_d >= {1'b0, dsr_q};
        rem_d    = ge_d ? SW'(rem_sh_d - {1'b0, dsr_q})
                        : rem_sh_d[SW-1:0];
        quo_d    = {quo_q[DW-2:0], ge_d};
        // 2R >= S at SW+1 bits decides the half-up carry
        rup_d    = (ROUND != 0) && ({rem_q, 1'b0} >= {1'b0, dsr_q});
        qr_d     = {1'b0, quo_q} + (DW+1)'(rup_d);
        ovf_d    = qr_d[DW:QW] != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            rsat_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n1_q    <= '0;
            sat_q   <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dsr_q <= bus.divisor;
                        quo_q <= bus.dividend;
                        rem_q <= '0;
                        cnt_q <= CW'(DW - 1);
                        if (bus.divisor == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= RND;
                end
                RND: begin
                    res_q   <= ovf_d ? '1 : qr_d[QW-1:0];
                    rsat_q  <= ovf_d;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    n1_q    <= dz_q ? '1 : res_q;
                    sat_q   <= dz_q ? 1'b1 : rsat_q;
                    dzo_q   <= dz_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.n1       = n1_q;
    assign bus.sat      = sat_q;
    assign bus.div_zero = dzo_q;
endmodule
